// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: NSEG stages of SEG_W bits each, valid/ready handshake.
// Optional macro CLA_SATURATE_EN enables saturating results on overflow.
module cla_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             of,
    output logic             zf,
    output logic             nf
);

    localparam int NSEG = WIDTH / SEG_W;
    localparam int NG   = SEG_W / 4;
    localparam int NMID = (NSEG > 1) ? NSEG - 1 : 1;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             sub;
        logic             sgn;
    } stage_t;

    typedef struct packed {
        logic [SEG_W-1:0] s;
        logic             cout;
        logic             cmsb;
    } seg_res_t;

    // Two-level lookahead: group P/G feed flattened group-carry equations, so no carry ripples between groups.
    function automatic seg_res_t cla_seg(input logic [SEG_W-1:0] x,
                                         input logic [SEG_W-1:0] y,
                                         input logic             c0);
        logic [SEG_W-1:0] p, g, c;
        logic [NG-1:0]    gp, gg;
        logic [NG:0]      gc;
        logic             term;
        seg_res_t         r;
        p  = x ^ y;
        g  = x & y;
        c  = '0;
        gc = '0;
        for (int j = 0; j < NG; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        gc[0] = c0;
        for (int j = 1; j <= NG; j++) begin
            for (int m = 0; m < j; m++) begin
                term = gg[m];
                for (int n = m + 1; n < j; n++) term = term & gp[n];
                gc[j] = gc[j] | term;
            end
            term = c0;
            for (int n = 0; n < j; n++) term = term & gp[n];
            gc[j] = gc[j] | term;
        end
        for (int j = 0; j < NG; j++) begin
            c[4*j] = gc[j];
            for (int i = 1; i < 4; i++) begin
                for (int m = 0; m < i; m++) begin
                    term = g[4*j+m];
                    for (int n = m + 1; n < i; n++) term = term & p[4*j+n];
                    c[4*j+i] = c[4*j+i] | term;
                end
                term = gc[j];
                for (int n = 0; n < i; n++) term = term & p[4*j+n];
                c[4*j+i] = c[4*j+i] | term;
            end
        end
        r.s    = p ^ c;
        r.cout = gc[NG];
        r.cmsb = c[SEG_W-1];
        return r;
    endfunction

    stage_t           pipe_q    [NMID];
    stage_t           stage_in  [NSEG];
    stage_t           stage_out [NSEG];
    seg_res_t         seg_res;
    logic             last_cmsb;
    logic             raw_of;
    logic [WIDTH-1:0] res_sum;
    logic             advance;

    assign advance  = !out_valid | out_ready;
    assign in_ready = advance;

    // Stage 0 inverts B and carry-in for subtraction; later stages consume the previous stage register.
    always_comb begin
        seg_res   = '0;
        last_cmsb = 1'b0;
        stage_in[0].v   = in_valid;
        stage_in[0].a   = a;
        stage_in[0].b   = op_sub ? ~b : b;
        stage_in[0].s   = '0;
        stage_in[0].c   = op_sub ? ~cin : cin;
        stage_in[0].sub = op_sub;
        stage_in[0].sgn = sign;
        for (int k = 1; k < NSEG; k++) stage_in[k] = pipe_q[k-1];
        for (int k = 0; k < NSEG; k++) begin
            seg_res = cla_seg(stage_in[k].a[k*SEG_W +: SEG_W], stage_in[k].b[k*SEG_W +: SEG_W],
                              stage_in[k].c);
            stage_out[k] = stage_in[k];
            stage_out[k].s[k*SEG_W +: SEG_W] = seg_res.s;
            stage_out[k].c = seg_res.cout;
            if (k == NSEG - 1) last_cmsb = seg_res.cmsb;
        end
    end

    // Unsigned subtract reports a borrow, i.e. the inverse of the raw carry.
    always_comb begin
        raw_of  = stage_out[NSEG-1].sgn ? (last_cmsb ^ stage_out[NSEG-1].c)
                                        : (stage_out[NSEG-1].sub ? ~stage_out[NSEG-1].c
                                                                 : stage_out[NSEG-1].c);
        res_sum = stage_out[NSEG-1].s;
`ifdef CLA_SATURATE_EN
        if (raw_of) begin
            if (stage_out[NSEG-1].sgn)
                res_sum = stage_out[NSEG-1].a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                       : {1'b0, {(WIDTH-1){1'b1}}};
            else
                res_sum = stage_out[NSEG-1].sub ? '0 : '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NMID; k++) pipe_q[k] <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            co        <= 1'b0;
            of        <= 1'b0;
            zf        <= 1'b0;
            nf        <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < NSEG - 1; k++) pipe_q[k] <= stage_out[k];
            out_valid <= stage_out[NSEG-1].v;
            sum       <= res_sum;
            co        <= stage_out[NSEG-1].c;
            of        <= raw_of;
            zf        <= (res_sum == '0);
            nf        <= res_sum[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed self-checking bench for cla_addsub_pipe (WIDTH=16, SEG_W=8, latency 2).
// Expected values follow CLA_SATURATE_EN when the macro is defined.
module tb_cla_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, cin, op_sub, sign;
    logic        out_valid, out_ready, co, of, zf, nf;
    logic [15:0] a, b, sum;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    cla_addsub_pipe #(.WIDTH(16), .SEG_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub), .sign(sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .co(co), .of(of), .zf(zf), .nf(nf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one bundle for one cycle; returns at the negedge after it was accepted.
    task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb_v,
                                 input logic tcin, input logic tsub, input logic tsign);
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; op_sub = tsub; sign = tsign; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic runDirected(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                               input logic tcin, input logic tsub, input logic tsign,
                               input logic [15:0] e_sum, input logic e_co, input logic e_of,
                               input logic e_zf, input logic e_nf);
        applyStimulus(ta, tb_v, tcin, tsub, tsign);
        checkOutput({tag, "_lat1"}, out_valid, 0);
        @(negedge clk);
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput({tag, "_sum"}, sum, e_sum);
        checkOutput({tag, "_co"}, co, e_co);
        checkOutput({tag, "_of"}, of, e_of);
        checkOutput({tag, "_zf"}, zf, e_zf);
        checkOutput({tag, "_nf"}, nf, e_nf);
    endtask

    initial begin
        int          sent, stall_left, seen, bad;
        bit          seen_first;
        logic [15:0] recv[$];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; op_sub = 1'b0; sign = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_sum", sum, 0);
        checkOutput("rst_co", co, 0);

        runDirected("u_add_carry", 16'h00FF, 16'h0001, 0, 0, 0, 16'h0100, 0, 0, 0, 0);
        runDirected("u_add_cin",   16'h1234, 16'h4321, 1, 0, 0, 16'h5556, 0, 0, 0, 0);
        runDirected("s_add_neg",   16'hFFFE, 16'hFFFD, 0, 0, 1, 16'hFFFB, 1, 0, 0, 1);
        runDirected("s_sub_bin",   16'h0005, 16'h0003, 1, 1, 1, 16'h0001, 1, 0, 0, 0);
`ifdef CLA_SATURATE_EN
        runDirected("u_add_ovf",   16'hFFFF, 16'h0001, 0, 0, 0, 16'hFFFF, 1, 1, 0, 1);
        runDirected("s_add_ovf",   16'h7FFF, 16'h0001, 0, 0, 1, 16'h7FFF, 0, 1, 0, 0);
        runDirected("s_sub_ovf",   16'h8000, 16'h0001, 0, 1, 1, 16'h8000, 1, 1, 0, 1);
        runDirected("u_sub_brw",   16'h0003, 16'h0005, 0, 1, 0, 16'h0000, 0, 1, 1, 0);
`else
        runDirected("u_add_ovf",   16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000, 1, 1, 1, 0);
        runDirected("s_add_ovf",   16'h7FFF, 16'h0001, 0, 0, 1, 16'h8000, 0, 1, 0, 1);
        runDirected("s_sub_ovf",   16'h8000, 16'h0001, 0, 1, 1, 16'h7FFF, 1, 1, 0, 0);
        runDirected("u_sub_brw",   16'h0003, 16'h0005, 0, 1, 0, 16'hFFFE, 0, 1, 0, 1);
`endif

        // Backpressure: four back-to-back adds, consumer stalls 3 cycles on the first result.
        sent = 0; stall_left = 0; seen_first = 0;
        op_sub = 1'b0; sign = 1'b0; cin = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (out_valid && !seen_first) begin
                seen_first = 1;
                stall_left = 3;
            end
            out_ready = (stall_left == 0);
            in_valid  = (sent < 4);
            a = 16'(sent + 1);
            b = 16'(sent + 1);
            #1;
            if (stall_left > 0) begin
                checkOutput("bp_in_ready", in_ready, 0);
                checkOutput("bp_stable_sum", sum, 16'h0002);
                stall_left--;
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) recv.push_back(sum);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checkOutput("bp_count", recv.size(), 4);
        for (int i = 0; i < 4; i++)
            checkOutput("bp_order", (i < recv.size()) ? recv[i] : 16'hDEAD, 32'(2 * (i + 1)));

        // Reset while a result is held at the output.
        out_ready = 1'b0;
        applyStimulus(16'h7FFF, 16'h0001, 0, 0, 1);
        @(negedge clk);
        checkOutput("hold_valid", out_valid, 1);
        @(negedge clk);
`ifdef CLA_SATURATE_EN
        checkOutput("hold_sum", sum, 16'h7FFF);
`else
        checkOutput("hold_sum", sum, 16'h8000);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        checkOutput("rst2_valid", out_valid, 0);
        checkOutput("rst2_sum", sum, 0);
        checkOutput("rst2_of", of, 0);
        checkOutput("rst2_nf", nf, 0);
        checkOutput("rst2_in_ready", in_ready, 1);

        // Reset mid-operation, including a bundle offered in the reset cycle itself.
        seen = 0; bad = 0;
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 0; op_sub = 0; sign = 0; in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b1; a = 16'h0101; b = 16'h0101;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        if (out_valid) seen++;
        if (sum == 16'h2345) bad++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
            if (sum == 16'h2345) bad++;
        end
        checkOutput("midrst_no_valid", seen, 0);
        checkOutput("midrst_no_2345", bad, 0);
        runDirected("post_rst", 16'h0001, 16'h0002, 0, 0, 0, 16'h0003, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; next generation of the team's fixed 16-bit combinational CLA add/sub.
- Operand width is split into SEG_W-bit segments. Each segment is a 4-bit-group lookahead adder. Pipeline registers sit between segments.
- Adds a valid/ready handshake with backpressure, per-operation signed/unsigned mode, and a full status-flag set.
- Sits between operand-fetch logic and the writeback/flag-register stage of the datapath.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SEG_W.
- SEG_W, 8, bits computed per pipeline stage; must be a multiple of 4.
- NSEG, WIDTH/SEG_W (derived localparam), number of stages; latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for add; borrow-in for sub.
- op_sub  in  1  0 = add, 1 = subtract.
- sign  in  1  1 = signed (two's complement) overflow rules; 0 = unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- co  out  1  raw carry out of the MSB.
- of  out  1  overflow.
- zf  out  1  sum == 0.
- nf  out  1  sum[WIDTH-1].

Behaviour:
- Operation:
  - add: A + B + cin.
  - sub: A + ~B + ~cin, i.e. A - B - cin.
  - B is inverted and carry-in is formed at stage 0.
- Segmentation:
  - Stage k computes bits [k*SEG_W +: SEG_W] from its registered carry-in and registers its carry-out for stage k+1.
  - Stage k forwards the still-unprocessed upper operand bits, the completed lower sum bits, op_sub and sign.
- Carry-lookahead: each 4-bit group produces P/G. A second-level lookahead within the segment forms group carries. There is no ripple between groups.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance.
  - When advance is high, every stage register loads from the stage before it, including valid bits.
  - When advance is low, all stages hold.
  - A bundle is accepted when in_valid & in_ready.
  - A bubble (valid=0) moves through the pipe like data.
  - Results leave in order, each exactly once.
- Latency: NSEG cycles from acceptance to out_valid, assuming no stall.
  - For NSEG=1 the block is a single registered stage.
  - Throughput is 1 op/cycle while out_ready=1.
- Flags (computed at the final stage):
  - Unsigned add: of = co.
  - Unsigned sub: of = ~co (borrow).
  - Signed: of = carry into MSB XOR co.
  - zf and nf are computed from the final driven sum.
- Outputs are held stable while out_valid=1 & out_ready=0.
- Reset:
  - Clears all stage valid bits.
  - out_valid=0, sum=0, co=0, of=0, zf=0, nf=0, in_ready=1 in the cycle after rst.
  - Any in-flight operation is discarded, including one accepted in the same cycle rst is high; no result emerges.
- Simultaneous in accept and out accept in one cycle: permitted; both happen.

Optional Feature:
- Macro: CLA_SATURATE_EN.
- Defined, signed overflow (sign=1, of=1): sum saturates to the most-positive value when A's MSB=0, or the most-negative value when A's MSB=1.
- Defined, unsigned overflow (sign=0, of=1): sum saturates to all-ones for add, all-zeros for sub.
- Defined: of still reports the raw overflow; zf/nf reflect the saturated sum.
- Not defined: wrap-around result; no saturation logic is synthesised.

Test Plan (WIDTH=16, SEG_W=8, latency 2):
- Add, unsigned: 0x00FF + 0x0001, cin=0 -> sum=0x0100, co=0, of=0, zf=0; out_valid exactly 2 cycles after acceptance. Checks the inter-segment carry.
- Add, unsigned: 0xFFFF + 0x0001 -> sum=0x0000, co=1, of=1, zf=1, nf=0.
- Signed add: 0x7FFF + 0x0001 -> sum=0x8000, of=1, nf=1. With CLA_SATURATE_EN -> sum=0x7FFF, of=1, nf=0.
- Signed sub: 0x8000 - 0x0001, cin=0 -> sum=0x7FFF, of=1. With CLA_SATURATE_EN -> sum=0x8000. Unsigned sub 0x0003 - 0x0005 -> sum=0xFFFE, co=0, of=1.
- Backpressure: stream ops 1+1, 2+2, 3+3, 4+4 with in_valid held high; hold out_ready=0 for 3 cycles after the first out_valid -> in_ready drops while the pipe is full; results 2, 4, 6, 8 emerge in order, none lost or duplicated; sum is stable during the stall.
- Reset mid-operation: accept 0x1234 + 0x1111, assert rst the next cycle for 1 cycle -> out_valid stays 0 and 0x2345 never appears; a new op issued after reset completes normally.
